// File: rtl/inst_fetch_if.sv
`default_nettype none
// inst_fetch_if: instruction-memory bus plus decode handshake of the fetch stage.
// Rev 1.0
interface inst_fetch_if;
  logic [31:0] imem_address;
  logic        imem_read;
  logic        imem_waitrequest;
  logic        imem_readvalid;
  logic [31:0] imem_readdata;
  logic [31:0] instr_out;
  logic [31:0] pc4_out;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output imem_address, imem_read,
    input  imem_waitrequest, imem_readvalid, imem_readdata,
    output instr_out, pc4_out, instr_valid,
    input  instr_ready
  );

  modport slave (
    input  imem_address, imem_read,
    output imem_waitrequest, imem_readvalid, imem_readdata,
    input  instr_out, pc4_out, instr_valid,
    output instr_ready
  );
endinterface
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// inst_fetch: fetch PC, credit-limited imem requests, in-order {instr, pc4} queue to decode.
// Rev 1.0
module inst_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter int          DEPTH        = 2
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        clk_enable,
  input  wire logic        redirect,
  input  wire logic [31:0] redirect_pc,
  inst_fetch_if.master     bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W:0]    DEPTH_EXT = (CNT_W + 1)'(DEPTH);

  logic [31:0]       r_fetch_pc;
  logic [31:0]       r_addr_fifo [DEPTH];
  logic [ADDR_W-1:0] r_af_wr, r_af_rd;
  logic [31:0]       r_q_instr [DEPTH];
  logic [31:0]       r_q_pc4   [DEPTH];
  logic [ADDR_W-1:0] r_q_wr, r_q_rd;
  logic [CNT_W-1:0]  r_q_count, r_outstanding, r_drop;

  logic              w_nonempty, w_pop, w_credit, w_read, w_accept, w_resp, w_push;
  logic [CNT_W:0]    w_inflight;
  logic [31:0]       w_resp_pc4;

  assign w_nonempty = (r_q_count != '0);
  assign w_pop      = w_nonempty & bus.instr_ready & clk_enable & ~redirect;
  // A slot freed by this cycle's pop is reusable at once; this sustains one fetch per cycle.
  assign w_inflight = {1'b0, r_outstanding} + {1'b0, r_q_count} - (CNT_W + 1)'(w_pop);
  assign w_credit   = (w_inflight < DEPTH_EXT);
  assign w_read     = ~reset & clk_enable & ~redirect & w_credit;
  assign w_accept   = w_read & ~bus.imem_waitrequest;
  assign w_resp     = bus.imem_readvalid & (r_outstanding != '0);
  assign w_push     = w_resp & (r_drop == '0) & ~redirect;
  assign w_resp_pc4 = r_addr_fifo[r_af_rd] + 32'd4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc    <= RESET_VECTOR;
      r_af_wr       <= '0;
      r_af_rd       <= '0;
      r_q_wr        <= '0;
      r_q_rd        <= '0;
      r_q_count     <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      if (w_accept) r_af_wr <= r_af_wr + PTR_ONE;
      if (w_resp)   r_af_rd <= r_af_rd + PTR_ONE;

      if (redirect)      r_fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      else if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;

      case ({w_accept, w_resp})
        2'b10:   r_outstanding <= r_outstanding + CNT_ONE;
        2'b01:   r_outstanding <= r_outstanding - CNT_ONE;
        default: r_outstanding <= r_outstanding;
      endcase

      // Every request still in flight after this cycle belongs to the old stream.
      if (redirect)                     r_drop <= r_outstanding - (w_resp ? CNT_ONE : '0);
      else if (w_resp && r_drop != '0)  r_drop <= r_drop - CNT_ONE;

      if (redirect) begin
        r_q_wr    <= '0;
        r_q_rd    <= '0;
        r_q_count <= '0;
      end else begin
        if (w_push) r_q_wr <= r_q_wr + PTR_ONE;
        if (w_pop)  r_q_rd <= r_q_rd + PTR_ONE;
        case ({w_push, w_pop})
          2'b10:   r_q_count <= r_q_count + CNT_ONE;
          2'b01:   r_q_count <= r_q_count - CNT_ONE;
          default: r_q_count <= r_q_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_addr_fifo[r_af_wr] <= r_fetch_pc;
    if (w_push) begin
      r_q_instr[r_q_wr] <= bus.imem_readdata;
      r_q_pc4[r_q_wr]   <= w_resp_pc4;
    end
  end

  assign bus.imem_address = r_fetch_pc;
  assign bus.imem_read    = w_read;
  assign bus.instr_valid  = w_nonempty;
  assign bus.instr_out    = w_nonempty ? r_q_instr[r_q_rd] : 32'h0;
  assign bus.pc4_out      = w_nonempty ? r_q_pc4[r_q_rd]   : 32'h0;
endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// tb_inst_fetch: scoreboard bench with an in-order latency memory model and a decode sink.
// Rev 1.0
module tb_inst_fetch;
  localparam logic [31:0] RV    = 32'hBFC00000;
  localparam int          DEPTH = 2;

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic        redirect;
  logic [31:0] redirect_pc;

  inst_fetch_if bus ();

  inst_fetch #(.RESET_VECTOR(RV), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .clk_enable  (clk_enable),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; bit stale; } mreq_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc4; } exp_t;

  mreq_t memq[$];
  exp_t  sb[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc, lat, first_valid, n_pops;
  logic [31:0] model_pc, target, mask, first_pop_instr, first_pop_pc4;
  bit          first_pop_seen;
  logic        waitreq_v, ready_v, ce_v, redirect_v;
  logic        obs_read, obs_valid;
  logic [31:0] obs_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step();
    logic resp, pop_e, read_e;
    int   credit;
    mreq_t r;
    resp = (memq.size() > 0) && (memq[0].due == cyc);
    bus.imem_readvalid   = resp;
    bus.imem_readdata    = resp ? (memq[0].addr ^ mask) : 32'h0;
    bus.imem_waitrequest = waitreq_v;
    bus.instr_ready      = ready_v;
    clk_enable           = ce_v;
    redirect             = redirect_v;
    redirect_pc          = target;
    #1;
    obs_read  = bus.imem_read;
    obs_valid = bus.instr_valid;
    obs_addr  = bus.imem_address;
    check("instr_valid", bus.instr_valid, (sb.size() != 0));
    if (sb.size() == 0) begin
      check("instr_out_empty", bus.instr_out, 32'h0);
      check("pc4_out_empty", bus.pc4_out, 32'h0);
    end
    if (bus.instr_valid && first_valid < 0) first_valid = cyc;
    pop_e  = (sb.size() != 0) && ready_v && ce_v && !redirect_v;
    // A slot being popped this cycle counts as free for a new request.
    credit = memq.size() + sb.size() - (pop_e ? 1 : 0);
    read_e = ce_v && !redirect_v && (credit < DEPTH);
    if (pop_e) begin
      check("instr_out", bus.instr_out, sb[0].instr);
      check("pc4_out", bus.pc4_out, sb[0].pc4);
      if (!first_pop_seen) begin
        first_pop_seen  = 1'b1;
        first_pop_instr = bus.instr_out;
        first_pop_pc4   = bus.pc4_out;
      end
      void'(sb.pop_front());
      n_pops++;
    end
    check("imem_read", bus.imem_read, read_e);
    if (read_e) check("imem_address", bus.imem_address, model_pc);
    if (resp) begin
      r = memq.pop_front();
      if (!r.stale && !redirect_v) sb.push_back('{r.addr ^ mask, r.addr + 32'd4});
    end
    if (read_e && !waitreq_v) begin
      memq.push_back('{model_pc, cyc + lat, 1'b0});
      model_pc = model_pc + 32'd4;
    end
    if (redirect_v) begin
      sb.delete();
      foreach (memq[i]) memq[i].stale = 1'b1;
      model_pc       = target & 32'hFFFF_FFFC;
      first_pop_seen = 1'b0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset              = 1'b1;
    redirect           = 1'b0;
    redirect_v         = 1'b0;
    bus.imem_readvalid = 1'b0;
    #1;
    check("rst_instr_valid", bus.instr_valid, 1'b0);
    check("rst_imem_read", bus.imem_read, 1'b0);
    check("rst_imem_address", bus.imem_address, RV);
    check("rst_instr_out", bus.instr_out, 32'h0);
    check("rst_pc4_out", bus.pc4_out, 32'h0);
    sb.delete();
    memq.delete();
    model_pc = RV;
    @(negedge clk);
    @(negedge clk);
    reset          = 1'b0;
    cyc            = 0;
    first_valid    = -1;
    n_pops         = 0;
    first_pop_seen = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clk_enable = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    bus.imem_waitrequest = 1'b0; bus.imem_readvalid = 1'b0;
    bus.imem_readdata = 32'h0; bus.instr_ready = 1'b1;
    waitreq_v = 1'b0; ready_v = 1'b1; ce_v = 1'b1; redirect_v = 1'b0;
    lat = 1; target = 32'h0; mask = 32'h0; cyc = 0;
    @(negedge clk);

    // Zero-wait streaming: one instruction per cycle from cycle 2.
    do_reset();
    repeat (10) step();
    check("t1_first_valid", first_valid, 2);
    check("t1_pops", n_pops, 8);
    check("t1_first_instr", first_pop_instr, RV);
    check("t1_first_pc4", first_pop_pc4, RV + 32'd4);

    // Wait-request on the first request delays everything by three cycles.
    do_reset();
    waitreq_v = 1'b1;
    repeat (3) step();
    check("t2_held_read", obs_read, 1'b1);
    check("t2_held_addr", obs_addr, RV);
    waitreq_v = 1'b0;
    repeat (6) step();
    check("t2_first_valid", first_valid, 5);

    // Decode back-pressure: queue fills, requests stop, nothing lost.
    do_reset();
    ready_v = 1'b0;
    repeat (5) step();
    check("t3_full_read", obs_read, 1'b0);
    check("t3_full_valid", obs_valid, 1'b1);
    ready_v = 1'b1;
    repeat (6) step();
    check("t3_first_instr", first_pop_instr, RV);
    check("t3_pops", n_pops, 6);

    // Latency-3 memory with two stale requests in flight at redirect.
    do_reset();
    lat = 3;
    repeat (2) step();
    redirect_v = 1'b1; target = 32'h00400000;
    step();
    redirect_v = 1'b0;
    repeat (10) step();
    check("t4_first_instr", first_pop_instr, 32'h00400000);
    check("t4_first_pc4", first_pop_pc4, 32'h00400004);

    // Redirect coinciding with a response and a ready decode.
    do_reset();
    lat = 1;
    repeat (4) step();
    redirect_v = 1'b1; target = 32'h00001002;
    step();
    check("t5_no_read_in_redirect", obs_read, 1'b0);
    redirect_v = 1'b0;
    step();
    check("t5_queue_empty", obs_valid, 1'b0);
    check("t5_read_next", obs_read, 1'b1);
    check("t5_addr_next", obs_addr, 32'h00001000);
    repeat (6) step();
    check("t5_first_instr", first_pop_instr, 32'h00001000);

    // Clock-enable gap, then data distinct from address.
    ce_v = 1'b0;
    repeat (3) step();
    ce_v = 1'b1;
    mask = 32'hFFFF0000;
    repeat (6) step();

    // Reset while the queue is full; fetch restarts at the reset vector.
    ready_v = 1'b0;
    repeat (4) step();
    do_reset();
    mask = 32'h0;
    ready_v = 1'b1;
    repeat (6) step();
    check("t7_first_valid", first_valid, 2);
    check("t7_first_instr", first_pop_instr, RV);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
